// File: rtl/srfpu_mem_arbiter.sv
// srfpu_mem_arbiter
// Shares one native memory port (valid/ready, addr, wdata, wstrb, rdata)
// between the integer core and the SRFPU load/store path. Each transaction
// is granted whole and is never pre-empted. Ties are broken against the
// last tie winner. Every transaction passes through one IDLE cycle.
//
// Optional feature, macro SRFPU_ARB_TIMEOUT_EN: a watchdog that aborts a
// transaction the memory never acknowledges. It answers the owner with
// ERR_DATA and pulses timeout_err. With the macro undefined no counter is
// built and BUSY waits for mem_ready indefinitely.
module srfpu_mem_arbiter #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_mem_valid,
  input  logic [ADDR_WIDTH-1:0]   cpu_mem_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] cpu_mem_wstrb,
  output logic                    cpu_mem_ready,
  output logic [DATA_WIDTH-1:0]   cpu_mem_rdata,
  input  logic                    fpu_mem_valid,
  input  logic [ADDR_WIDTH-1:0]   fpu_mem_addr,
  input  logic [DATA_WIDTH-1:0]   fpu_mem_wdata,
  input  logic [DATA_WIDTH/8-1:0] fpu_mem_wstrb,
  output logic                    fpu_mem_ready,
  output logic [DATA_WIDTH-1:0]   fpu_mem_rdata,
  output logic                    mem_valid,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [1:0]              grant_test,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_BUSY_CPU = 2'b01,
    ST_BUSY_FPU = 2'b10
  } state_t;

  state_t state_r;
  // Master that won the most recent tie: 1'b0 = core, 1'b1 = FPU.
  logic   last_grant_r;

  logic   in_busy_s;
  logic   owner_valid_s;
  logic   timeout_s;

  assign in_busy_s     = (state_r == ST_BUSY_CPU) || (state_r == ST_BUSY_FPU);
  assign owner_valid_s = (state_r == ST_BUSY_FPU) ? fpu_mem_valid : cpu_mem_valid;

`ifdef SRFPU_ARB_TIMEOUT_EN
  // stall_cnt_r is the number of earlier BUSY cycles of this transaction
  // that ended without mem_ready; it is 0 in the first BUSY cycle, so the
  // abort lands in the TIMEOUT_CYCLES-th stalled BUSY cycle. mem_ready in
  // the same cycle always wins over the abort.
  logic [15:0] stall_cnt_r;

  assign timeout_s = in_busy_s && owner_valid_s && !mem_ready && !reset &&
                     (stall_cnt_r == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog counter: held at zero outside BUSY, counts stalled BUSY cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 16'd0;
    end else if (state_r == ST_IDLE) begin
      stall_cnt_r <= 16'd0;
    end else if (!mem_ready && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_s = 1'b0;
`endif

  // Arbitration FSM: pick an owner from IDLE, release it on completion,
  // abort, or the owner withdrawing its request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cpu_mem_valid && fpu_mem_valid) begin
            if (last_grant_r) begin
              state_r      <= ST_BUSY_CPU;
              last_grant_r <= 1'b0;
            end else begin
              state_r      <= ST_BUSY_FPU;
              last_grant_r <= 1'b1;
            end
          end else if (cpu_mem_valid) begin
            state_r <= ST_BUSY_CPU;
          end else if (fpu_mem_valid) begin
            state_r <= ST_BUSY_FPU;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY_CPU: begin
          if (!cpu_mem_valid || mem_ready || timeout_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_BUSY_CPU;
          end
        end
        ST_BUSY_FPU: begin
          if (!fpu_mem_valid || mem_ready || timeout_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_BUSY_FPU;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Port steering: the owner is connected straight through to the memory
  // (zero-latency completion); everything else reads zero. While reset is
  // asserted every output is forced to its reset value so an in-flight
  // mem_ready never reaches a master.
  always_comb begin
    mem_valid     = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wstrb     = '0;
    cpu_mem_ready = 1'b0;
    cpu_mem_rdata = '0;
    fpu_mem_ready = 1'b0;
    fpu_mem_rdata = '0;
    grant_test    = 2'b00;
    timeout_err   = 1'b0;
    if (!reset) begin
      case (state_r)
        ST_BUSY_CPU: begin
          grant_test    = 2'b01;
          mem_valid     = cpu_mem_valid & ~timeout_s;
          mem_addr      = cpu_mem_addr;
          mem_wdata     = cpu_mem_wdata;
          mem_wstrb     = cpu_mem_wstrb;
          cpu_mem_ready = cpu_mem_valid & (mem_ready | timeout_s);
          cpu_mem_rdata = timeout_s ? ERR_DATA : mem_rdata;
          timeout_err   = timeout_s;
        end
        ST_BUSY_FPU: begin
          grant_test    = 2'b10;
          mem_valid     = fpu_mem_valid & ~timeout_s;
          mem_addr      = fpu_mem_addr;
          mem_wdata     = fpu_mem_wdata;
          mem_wstrb     = fpu_mem_wstrb;
          fpu_mem_ready = fpu_mem_valid & (mem_ready | timeout_s);
          fpu_mem_rdata = timeout_s ? ERR_DATA : mem_rdata;
          timeout_err   = timeout_s;
        end
        default: begin
          grant_test = 2'b00;
        end
      endcase
    end else begin
      grant_test = 2'b00;
    end
  end

endmodule

// File: tb/tb_srfpu_mem_arbiter.sv
// Testbench for srfpu_mem_arbiter: directed scenarios plus randomized
// traffic from both masters against a bench-side memory. A cycle-rule
// reference model checks every output on every cycle, and a per-master
// scoreboard checks returned read data against a shadow memory image.
`timescale 1ns/1ps
module tb_srfpu_mem_arbiter;
  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  typedef struct packed {
    logic        chk;
    logic [31:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic cpu_valid, fpu_valid;
  logic [31:0] cpu_addr, cpu_wdata, fpu_addr, fpu_wdata;
  logic [3:0]  cpu_wstrb, fpu_wstrb;
  logic cpu_ready, fpu_ready;
  logic [31:0] cpu_rdata, fpu_rdata;
  logic mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  grant_test;
  logic        timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic [1:0] grant_log[$];
  logic [1:0] prev_grant = 2'b00;

  logic [31:0] mem_arr[256];
  logic [31:0] shadow[256];

  bit          auto_mem  = 1'b0;
  bit          zero_wait = 1'b0;
  logic        man_ready = 1'b0;
  logic [31:0] man_rdata = 32'h0;

  srfpu_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_valid(cpu_valid), .cpu_mem_addr(cpu_addr), .cpu_mem_wdata(cpu_wdata),
    .cpu_mem_wstrb(cpu_wstrb), .cpu_mem_ready(cpu_ready), .cpu_mem_rdata(cpu_rdata),
    .fpu_mem_valid(fpu_valid), .fpu_mem_addr(fpu_addr), .fpu_mem_wdata(fpu_wdata),
    .fpu_mem_wstrb(fpu_wstrb), .fpu_mem_ready(fpu_ready), .fpu_mem_rdata(fpu_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant_test(grant_test), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  task automatic drive(input int m, input logic v, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    if (m == 0) begin cpu_valid = v; cpu_addr = a; cpu_wdata = d; cpu_wstrb = s; end
    else        begin fpu_valid = v; fpu_addr = a; fpu_wdata = d; fpu_wstrb = s; end
  endtask

  task automatic set_valid(input int m, input logic v);
    if (m == 0) cpu_valid = v;
    else        fpu_valid = v;
  endtask

  task automatic push_exp(input int m, input logic c, input logic [31:0] d);
    exp_t e;
    e.chk = c;
    e.d   = d;
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic logic ready_of(input int m);
    return (m == 0) ? cpu_ready : fpu_ready;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard pop: every ready the DUT presents must match a queued expectation.
  task automatic sb_pop(input int m, input logic [31:0] act);
    exp_t e;
    n_checks++;
    if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
      $display("FAIL sb_unexpected_ready m%0d: got ready with rdata 0x%0h, want no ready at %0t",
               m, act, $time);
    end else begin
      e = (m == 0) ? q0.pop_front() : q1.pop_front();
      if (!e.chk || act === e.d) n_pass++;
      else $display("FAIL sb_rdata m%0d: got 0x%0h, want 0x%0h at %0t", m, act, e.d, $time);
    end
  endtask

  // Reference model state, expressed as owner number (0 none, 1 core, 2 FPU)
  // and the count of BUSY cycles so far including the current one.
  int   model_owner = 0;
  bit   model_last_fpu = 1'b1;
  int   model_busy = 0;
  logic ov, e_to, e_mv, e_rdy0, e_rdy1;
  logic [1:0]  e_grant;
  logic [31:0] e_ma, e_mw, e_rd0, e_rd1, rd;
  logic [3:0]  e_ms;

  // Monitor: compare all outputs to the model, feed the scoreboard, advance the model.
  initial forever begin
    @(negedge clk);
    ov = 1'b0; e_to = 1'b0; e_mv = 1'b0; e_rdy0 = 1'b0; e_rdy1 = 1'b0;
    e_grant = 2'b00; e_ma = 32'h0; e_mw = 32'h0; e_ms = 4'h0; e_rd0 = 32'h0; e_rd1 = 32'h0;
    if (!reset && model_owner != 0) begin
      ov      = (model_owner == 1) ? cpu_valid : fpu_valid;
      e_grant = (model_owner == 1) ? 2'b01 : 2'b10;
`ifdef SRFPU_ARB_TIMEOUT_EN
      e_to = ov && !mem_ready && (model_busy == TO);
`endif
      e_mv = ov && !e_to;
      e_ma = (model_owner == 1) ? cpu_addr  : fpu_addr;
      e_mw = (model_owner == 1) ? cpu_wdata : fpu_wdata;
      e_ms = (model_owner == 1) ? cpu_wstrb : fpu_wstrb;
      rd   = e_to ? ERR : mem_rdata;
      if (model_owner == 1) begin e_rdy0 = ov && (mem_ready || e_to); e_rd0 = rd; end
      else                  begin e_rdy1 = ov && (mem_ready || e_to); e_rd1 = rd; end
    end
    chk("grant_test", grant_test, e_grant);
    chk("mem_ctl", {mem_valid, mem_wstrb, mem_addr}, {e_mv, e_ms, e_ma});
    chk("mem_wdata", mem_wdata, e_mw);
    chk("cpu_resp", {cpu_ready, cpu_rdata}, {e_rdy0, e_rd0});
    chk("fpu_resp", {fpu_ready, fpu_rdata}, {e_rdy1, e_rd1});
    chk("timeout_err", timeout_err, e_to);
    if (cpu_ready === 1'b1) sb_pop(0, cpu_rdata);
    if (fpu_ready === 1'b1) sb_pop(1, fpu_rdata);
    if (grant_test != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant_test);
    prev_grant = grant_test;
    if (reset) begin
      model_owner = 0; model_last_fpu = 1'b1; model_busy = 0;
    end else if (model_owner == 0) begin
      if (cpu_valid && fpu_valid) begin
        model_owner    = model_last_fpu ? 1 : 2;
        model_last_fpu = (model_owner == 2);
      end else if (cpu_valid) model_owner = 1;
      else if (fpu_valid)     model_owner = 2;
      model_busy = (model_owner != 0) ? 1 : 0;
    end else if (!ov || mem_ready || e_to) begin
      model_owner = 0; model_busy = 0;
    end else begin
      model_busy++;
    end
  end

  // Bench memory: random latency (or zero-wait) in auto mode, manual values otherwise.
  int wait_cnt = 0;
  int lat = 0;
  initial forever begin
    @(posedge clk);
    #2;
    if (!auto_mem) begin
      wait_cnt  = 0;
      mem_ready = man_ready;
      mem_rdata = man_rdata;
    end else if (mem_valid === 1'b1) begin
      if (wait_cnt >= lat) begin
        mem_ready = 1'b1;
        mem_rdata = mem_arr[mem_addr[9:2]];
        if (mem_wstrb != 4'h0) mem_arr[mem_addr[9:2]] = merge(mem_arr[mem_addr[9:2]], mem_wdata, mem_wstrb);
        wait_cnt = 0;
        lat = zero_wait ? 0 : $urandom_range(0, 2);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        wait_cnt++;
      end
    end else begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
  end

  // One master issuing n random transactions into its own address region.
  task automatic run_master(input int m, input int n, input int maxgap);
    int gap, idx, guard;
    logic [31:0] d;
    logic [3:0]  s;
    tick();
    for (int k = 0; k < n; k++) begin
      gap = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
      if (gap > 0) begin
        set_valid(m, 1'b0);
        repeat (gap) @(posedge clk);
        #1;
      end
      idx = (m == 0) ? $urandom_range(0, 127) : 128 + $urandom_range(0, 127);
      d   = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        s = 4'($urandom_range(1, 15));
        push_exp(m, 1'b0, 32'h0);
        shadow[idx] = merge(shadow[idx], d, s);
      end else begin
        s = 4'h0;
        push_exp(m, 1'b1, shadow[idx]);
      end
      drive(m, 1'b1, 32'(idx * 4), d, s);
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (ready_of(m) !== 1'b1 && guard < 200);
      if (guard >= 200) begin
        n_checks++;
        $display("FAIL master_wait m%0d: got no ready in 200 cycles, want ready at %0t", m, $time);
      end
      tick();
    end
    set_valid(m, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200us, want finish");
    $fatal(1, "simulation time limit");
  end

  int stall_bad;

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
      shadow[i]  = mem_arr[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_grant", grant_test, 2'b00);
    chk("reset_outputs", {mem_valid, cpu_ready, fpu_ready, timeout_err}, 4'b0000);
    #1;
    do_reset();

    // Core-only read: one-cycle request latency, zero-latency completion.
    drive(0, 1'b1, 32'h100, 32'h0, 4'h0);
    push_exp(0, 1'b1, 32'h12345678);
    @(negedge clk); chk("t1_idle_cycle", mem_valid, 1'b0);
    tick();
    @(negedge clk); chk("t1_req_latency", {mem_valid, mem_addr}, {1'b1, 32'h100});
    tick();
    @(negedge clk); chk("t1_stall", cpu_ready, 1'b0);
    tick();
    man_ready = 1'b1; man_rdata = 32'h12345678;
    @(negedge clk);
    chk("t1_done", {cpu_ready, cpu_rdata, fpu_ready}, {1'b1, 32'h12345678, 1'b0});
    tick();
    set_valid(0, 1'b0); man_ready = 1'b0;

    // Simultaneous continuous requests after reset: strict alternation, core first.
    do_reset();
    grant_log.delete();
    zero_wait = 1'b1; auto_mem = 1'b1;
    fork
      run_master(0, 4, 0);
      run_master(1, 4, 0);
    join
    auto_mem = 1'b0; zero_wait = 1'b0;
    tick();
    chk("alt_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < grant_log.size(); i++)
      chk($sformatf("alt_grant%0d", i), grant_log[i], (i % 2 == 0) ? 2'b01 : 2'b10);

    // FPU write with the core's request held off until fpu_mem_ready.
    drive(1, 1'b1, 32'h200, 32'h3F800000, 4'hF);
    push_exp(1, 1'b0, 32'h0);
    tick();
    @(negedge clk);
    chk("t3_payload", {mem_valid, mem_addr, mem_wstrb}, {1'b1, 32'h200, 4'hF});
    chk("t3_wdata", mem_wdata, 32'h3F800000);
    tick();
    drive(0, 1'b1, 32'h104, 32'h0, 4'h0);
    push_exp(0, 1'b1, 32'hCAFEF00D);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); chk("t3_hold", {grant_test, cpu_ready}, {2'b10, 1'b0});
      tick();
    end
    man_ready = 1'b1; man_rdata = 32'h0;
    @(negedge clk); chk("t3_fpu_ready", fpu_ready, 1'b1);
    tick();
    set_valid(1, 1'b0); man_ready = 1'b0;
    @(negedge clk); chk("t3_bubble", grant_test, 2'b00);
    tick();
    @(negedge clk); chk("t3_core_grant", {grant_test, mem_addr}, {2'b01, 32'h104});
    tick();
    man_ready = 1'b1; man_rdata = 32'hCAFEF00D;
    @(negedge clk); chk("t3_core_ready", cpu_ready, 1'b1);
    tick();
    set_valid(0, 1'b0); man_ready = 1'b0;

    // Reset in BUSY_FPU with mem_ready high: FPU never sees ready.
    drive(1, 1'b1, 32'h208, 32'h0, 4'h0);
    tick();
    @(negedge clk); chk("t4_busy", grant_test, 2'b10);
    tick();
    reset = 1'b1; man_ready = 1'b1; man_rdata = 32'h77777777;
    @(negedge clk); chk("t4_no_ready", fpu_ready, 1'b0);
    tick();
    reset = 1'b0; man_ready = 1'b0; set_valid(1, 1'b0);
    @(negedge clk);
    chk("t4_after", {grant_test, mem_valid, fpu_ready, fpu_rdata}, {2'b00, 1'b0, 1'b0, 32'h0});
    tick();

`ifdef SRFPU_ARB_TIMEOUT_EN
    // Watchdog abort in the TO-th stalled BUSY cycle.
    drive(0, 1'b1, 32'h10C, 32'h0, 4'h0);
    push_exp(0, 1'b1, ERR);
    tick();
    for (int b = 1; b <= TO; b++) begin
      @(negedge clk);
      if (b < TO) chk("t5_waiting", {cpu_ready, mem_valid, timeout_err}, 3'b010);
      else        chk("t5_abort", {cpu_ready, cpu_rdata, mem_valid, timeout_err}, {1'b1, ERR, 2'b01});
      tick();
    end
    set_valid(0, 1'b0);
    @(negedge clk); chk("t5_pulse_end", {timeout_err, grant_test}, 3'b000);
    tick();
`else
    // No watchdog: the request stays pending, then the core withdraws it.
    drive(0, 1'b1, 32'h10C, 32'h0, 4'h0);
    tick();
    stall_bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (cpu_ready !== 1'b0 || mem_valid !== 1'b1) stall_bad++;
      tick();
    end
    chk("t5_pending", 32'(stall_bad), 32'd0);
    set_valid(0, 1'b0);
    @(negedge clk); chk("t5_withdraw", {mem_valid, cpu_ready}, 2'b00);
    tick();
`endif

    // Owner drops valid in BUSY_CPU; pending FPU request follows.
    drive(0, 1'b1, 32'h110, 32'h0, 4'h0);
    tick();
    drive(1, 1'b1, 32'h20C, 32'h0, 4'h0);
    push_exp(1, 1'b1, 32'h0BADF00D);
    @(negedge clk); chk("t6_core_owner", grant_test, 2'b01);
    tick();
    set_valid(0, 1'b0);
    @(negedge clk); chk("t6_drop", {mem_valid, cpu_ready}, 2'b00);
    tick();
    @(negedge clk); chk("t6_bubble", grant_test, 2'b00);
    tick();
    @(negedge clk); chk("t6_fpu_grant", {grant_test, mem_addr}, {2'b10, 32'h20C});
    tick();
    man_ready = 1'b1; man_rdata = 32'h0BADF00D;
    @(negedge clk); chk("t6_fpu_ready", fpu_ready, 1'b1);
    tick();
    set_valid(1, 1'b0); man_ready = 1'b0;

    // Randomized traffic from both masters against the bench memory.
    do_reset();
    auto_mem = 1'b1;
    fork
      run_master(0, 60, 2);
      run_master(1, 60, 2);
    join
    auto_mem = 1'b0;
    repeat (3) tick();
    chk("sb_cpu_drain", 32'(q0.size()), 32'd0);
    chk("sb_fpu_drain", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/srfpu_mem_arbiter.md
# srfpu_mem_arbiter

Two-requester arbiter that shares the single native memory interface (valid/ready, addr, wdata, wstrb, rdata) between the integer core and the SRFPU's FP load/store path. It sits between both masters and the memory/bus. Each bus transaction is granted whole. Priority rotates between masters. The arbiter adds a fixed one-cycle arbitration bubble per transaction. An optional watchdog aborts transactions the memory never acknowledges.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width; `wstrb` is `DATA_WIDTH/8` bits.
- `TIMEOUT_CYCLES`, 255, watchdog limit in cycles (used only when `SRFPU_ARB_TIMEOUT_EN` is defined).
- `ERR_DATA`, 32'hDEADBEEF, read data returned on timeout.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_mem_valid`  in  1  core request.
- `cpu_mem_addr` / `cpu_mem_wdata` / `cpu_mem_wstrb`  in  ADDR/DATA/DATA/8  core request payload.
- `cpu_mem_ready`  out  1  core transaction complete.
- `cpu_mem_rdata`  out  DATA  core read data.
- `fpu_mem_valid` / `fpu_mem_addr` / `fpu_mem_wdata` / `fpu_mem_wstrb`  in  same widths  SRFPU request.
- `fpu_mem_ready`  out  1  SRFPU transaction complete.
- `fpu_mem_rdata`  out  DATA  SRFPU read data.
- `mem_valid`  out  1  downstream request.
- `mem_addr` / `mem_wdata` / `mem_wstrb`  out  ADDR/DATA/DATA/8  downstream payload.
- `mem_ready`  in  1  downstream completion.
- `mem_rdata`  in  DATA  downstream read data.
- `grant_test`  out  2  one-hot current owner: bit0 is core, bit1 is FPU.
- `timeout_err`  out  1  one-cycle pulse on watchdog abort.

## Operation
- States:
  - IDLE: no owner.
  - BUSY_CPU: core owns the memory port.
  - BUSY_FPU: SRFPU owns the memory port.
- `last_grant` register: reset value is FPU, so the core wins the first tie.

Transitions from IDLE:
- Only `cpu_mem_valid` high → BUSY_CPU.
- Only `fpu_mem_valid` high → BUSY_FPU.
- Both high → go to the master that is not `last_grant`, then update `last_grant` to that master.
- Neither high → stay in IDLE.

Behaviour in BUSY_x:
- `mem_valid` = 1.
- `mem_addr`, `mem_wdata` and `mem_wstrb` are combinationally muxed from master x.
- `x_mem_ready` = `mem_ready`.
- `x_mem_rdata` = `mem_rdata`.
- The other master sees ready = 0 and rdata = 0.
- On `mem_ready` = 1 → IDLE.

Other rules:
- In IDLE, `mem_valid`, `mem_wstrb`, both readys and both rdatas are 0. `mem_addr` and `mem_wdata` are 0.
- Masters must hold valid and payload stable until their ready. If the owner drops valid while in BUSY_x, the arbiter deasserts `mem_valid` in that same cycle and returns to IDLE next cycle. No ready is issued.
- A grant is never pre-empted. A request from the other master waits, with unbounded latency only if the memory stalls.
- Reset mid-transaction: on the next edge, state = IDLE and all outputs take their reset values. An in-flight downstream `mem_ready` is ignored.
- Reset values: state IDLE, `last_grant` = FPU, `grant_test` = 2'b00, `timeout_err` = 0, all other outputs 0.

## Timing
- Request latency: valid seen in IDLE at edge N gives `mem_valid` high from cycle N+1.
- Completion: ready and rdata to the owner appear in the same cycle as `mem_ready` (zero added latency).
- Back-to-back requests: at least one IDLE cycle between transactions, so peak throughput is one transaction per 2 cycles when memory is zero-wait.
- Fairness: with both masters continuously requesting, grants strictly alternate.

## Configuration
Macro `SRFPU_ARB_TIMEOUT_EN`.

When defined:
- An 8..16-bit counter clears on entry to BUSY_x and increments each BUSY cycle without `mem_ready`.
- When the counter reaches `TIMEOUT_CYCLES`, in that cycle:
  - `mem_valid` = 0.
  - `x_mem_ready` = 1 and `x_mem_rdata` = `ERR_DATA`.
  - `timeout_err` = 1.
- Next state is IDLE.
- `mem_ready` and the timeout in the same cycle: `mem_ready` wins and `timeout_err` stays 0.

When not defined:
- No counter is built.
- `timeout_err` is tied to 0.
- BUSY waits indefinitely for `mem_ready`.

## Test plan
- Core-only read: `cpu_mem_valid` = 1, addr 0x100, memory answers 2 cycles later with 0x12345678 → `mem_valid` rises 1 cycle after the request; `cpu_mem_ready` and rdata 0x12345678 appear in the `mem_ready` cycle; FPU ready stays 0.
- Simultaneous requests after reset: both valid, zero-wait memory → core is granted first (`grant_test` = 01), then FPU (10). Keeping both asserted gives alternation 01, 10, 01, 10 with one IDLE cycle between each.
- FPU write: addr 0x200, wdata 0x3F800000, wstrb 0xF → downstream payload matches exactly; the core's held request is granted only after `fpu_mem_ready`.
- Reset asserted in BUSY_FPU while `mem_ready` = 1 → next cycle all outputs are 0 and `grant_test` = 00; the FPU never sees ready.
- With `SRFPU_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, memory never ready → in the 4th BUSY cycle `cpu_mem_ready` = 1, rdata 0xDEADBEEF, `timeout_err` is a one-cycle pulse, then IDLE. Without the macro the request stays pending for at least 1000 cycles.
- Owner drops valid while in BUSY_CPU → `mem_valid` falls in the same cycle, no ready is issued, and a pending FPU request is granted afterwards.
